// File: rtl/wb_regfile.sv
// Write-back stage register file: 32x32 registers, write-through bypass on both
// asynchronous read ports, and a wrapping count of committed writes.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_reg_write,
  input  logic        in_mem_reg,
  input  logic [31:0] in_read_data_mem,
  input  logic [31:0] in_address_write,
  input  logic [4:0]  in_write_reg,
  input  logic [4:0]  read_reg_1,
  input  logic [4:0]  read_reg_2,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2,
  output logic [31:0] wb_data,
  output logic        wb_valid,
  output logic [15:0] wb_count
);

  logic [31:0] regs_q [32];
  logic [15:0] wb_count_q;
  logic [15:0] wb_count_d;

  // Index 0 reads as zero ahead of bypass; bypass only while a write is live.
  function automatic logic [31:0] read_port(
    input logic [4:0]  idx,
    input logic        wr_vld,
    input logic [4:0]  wr_idx,
    input logic [31:0] wr_data,
    input logic [31:0] stored
  );
    logic [31:0] res;
    res = stored;
    if (idx == 5'd0)
      res = 32'h0;
    else if (wr_vld && (idx == wr_idx))
      res = wr_data;
    return res;
  endfunction

  always_comb begin
    wb_data  = in_mem_reg ? in_read_data_mem : in_address_write;
    wb_valid = in_reg_write && !rst && (in_write_reg != 5'd0);
  end

  always_comb begin
    read_data_1 = read_port(read_reg_1, wb_valid, in_write_reg, wb_data, regs_q[read_reg_1]);
    read_data_2 = read_port(read_reg_2, wb_valid, in_write_reg, wb_data, regs_q[read_reg_2]);
  end

  always_comb begin
    wb_count_d = wb_count_q;
    if (wb_valid)
      wb_count_d = wb_count_q + 16'd1;
  end

  // Commit stage: reset wins over any same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        regs_q[i] <= 32'h0;
      wb_count_q <= 16'h0;
    end else begin
      if (wb_valid)
        regs_q[in_write_reg] <= wb_data;
      wb_count_q <= wb_count_d;
    end
  end

  assign wb_count = wb_count_q;

endmodule
